// File: rtl/data_memory_pkg.sv
// ---------------------------------------------------------------------------
// riscv_defs
//   Shared definitions for the RISC-V datapath blocks: bus widths, the
//   load/store funct3 encodings, the access-size encodings derived from
//   funct3[1:0], and the data-memory FSM state type.
//   Helper functions decode the access size into a misalignment flag and a
//   byte-lane write mask so every user agrees on the same rules.
// ---------------------------------------------------------------------------
package riscv_defs;

  localparam int NB_WORD   = 32;
  localparam int NB_ADDR   = 32;
  localparam int NB_FUNCT3 = 3;

  // Load/store funct3 encodings from the base ISA
  localparam logic [NB_FUNCT3-1:0] F3_LB  = 3'b000;
  localparam logic [NB_FUNCT3-1:0] F3_LH  = 3'b001;
  localparam logic [NB_FUNCT3-1:0] F3_LW  = 3'b010;
  localparam logic [NB_FUNCT3-1:0] F3_LBU = 3'b100;
  localparam logic [NB_FUNCT3-1:0] F3_LHU = 3'b101;
  localparam logic [NB_FUNCT3-1:0] F3_SB  = 3'b000;
  localparam logic [NB_FUNCT3-1:0] F3_SH  = 3'b001;
  localparam logic [NB_FUNCT3-1:0] F3_SW  = 3'b010;

  // Access size lives in funct3[1:0]; 2'b11 behaves as a word access
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } dmem_state_e;

  // A half must sit on an even byte, a word on a multiple of four
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] byte_off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = byte_off[0];
      default: mis = (byte_off != 2'b00);
    endcase
    return mis;
  endfunction

  // Which of the four byte lanes an aligned store of this size touches
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] byte_off);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << byte_off;
      SZ_HALF: mask = byte_off[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// ---------------------------------------------------------------------------
// dmem_if
//   Core-to-data-memory bus.
//   dmem_address   : byte address driven by the core
//   dmem_wr_data   : store data, right-aligned (byte in [7:0], half in [15:0])
//   dmem_wr_enable : store request for the current cycle
//   dmem_rd_data   : addressed word shifted right by the byte offset
//   Modports: cpu (requester side) and mem (responder side).
// ---------------------------------------------------------------------------
interface dmem_if;
  import riscv_defs::*;

  logic [NB_ADDR-1:0] dmem_address;
  logic [NB_WORD-1:0] dmem_wr_data;
  logic               dmem_wr_enable;
  logic [NB_WORD-1:0] dmem_rd_data;

  modport cpu (
    output dmem_address,
    output dmem_wr_data,
    output dmem_wr_enable,
    input  dmem_rd_data
  );

  modport mem (
    input  dmem_address,
    input  dmem_wr_data,
    input  dmem_wr_enable,
    output dmem_rd_data
  );

endinterface

// File: rtl/data_memory_byte_lane_ram.sv
// ---------------------------------------------------------------------------
// byte_lane_ram
//   Word storage split into four independent 8-bit lanes so that byte and
//   half stores only disturb the lanes they target. Writes happen on the
//   rising clock edge; reads are asynchronous, so a read of the word being
//   written in the same cycle still sees the old contents.
//   Storage is deliberately not reset.
//   Ports:
//     clk        : write clock
//     wr_index   : word index for the write
//     wr_lane_en : per-lane write enables, lane n = bits [8n+7:8n]
//     wr_data    : lane-positioned write data
//     rd_index   : word index for the asynchronous read
//     rd_data    : full 32-bit word at rd_index
// ---------------------------------------------------------------------------
module byte_lane_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] wr_index,
  input  logic [3:0]    wr_lane_en,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_index,
  output logic [31:0]   rd_data
);

  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    // Each lane only commits when its own enable is set
    always_ff @(posedge clk) begin
      if (wr_lane_en[lane]) begin
        lane_mem[wr_index] <= wr_data[8*lane +: 8];
      end
    end

    assign rd_data[8*lane +: 8] = lane_mem[rd_index];
  end

endmodule

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
//   Byte-addressable data memory for the RISC-V core.
//   After reset a clear sequence writes zero to every word, one per cycle,
//   with o_busy high; afterwards loads are served combinationally and
//   stores of byte/half/word size update only their lanes. Misaligned
//   stores are dropped and counted.
//   Ports:
//     i_clock        : clock, rising edge active
//     i_reset        : asynchronous active-low reset
//     DMEM_IF        : responder end of the data-memory bus (dmem_if.mem)
//     i_ld_st_funct3 : access size in bits [1:0] (byte/half/word, 11 = word)
//     o_busy         : high while the clear sequence runs
//     o_misaligned   : combinational misalignment flag for the current access
//     o_err_count    : saturating count of suppressed misaligned stores
// ---------------------------------------------------------------------------
module data_memory
  import riscv_defs::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  dmem_if.mem                  DMEM_IF,
  input  logic [NB_FUNCT3-1:0] i_ld_st_funct3,
  output logic                 o_busy,
  output logic                 o_misaligned,
  output logic [7:0]           o_err_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

  dmem_state_e   state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          busy_q, busy_d;
  logic [7:0]    err_count_q, err_count_d;

  logic [1:0]    size;
  logic [1:0]    byte_off;
  logic [AW-1:0] word_index;
  logic          access_misaligned;
  logic          store_dropped;

  logic [3:0]    ram_lane_en;
  logic [AW-1:0] ram_wr_index;
  logic [31:0]   ram_wr_data;
  logic [31:0]   ram_rd_word;

  // Address bits above the storage range wrap, and funct3[2] only selects
  // sign handling in the load unit, so neither matters here.
  logic unused_bits;
  assign unused_bits = ^{DMEM_IF.dmem_address[NB_ADDR-1:AW+2],
                         i_ld_st_funct3[NB_FUNCT3-1:2]};

  assign size       = i_ld_st_funct3[1:0];
  assign byte_off   = DMEM_IF.dmem_address[1:0];
  assign word_index = DMEM_IF.dmem_address[AW+1:2];

  // Misalignment is only reported once the memory is in service; the flag
  // is independent of whether a store is requested.
  assign access_misaligned = (state_q == S_READY) && is_misaligned(size, byte_off);
  assign store_dropped     = access_misaligned && DMEM_IF.dmem_wr_enable;

  // Storage write port: the clear sequence owns it while clearing, the bus
  // owns it afterwards. Store data is replicated across lanes so the lane
  // enables alone select where it lands.
  always_comb begin
    ram_lane_en  = 4'b0000;
    ram_wr_index = word_index;
    ram_wr_data  = DMEM_IF.dmem_wr_data;
    if (state_q == S_CLEAR) begin
      ram_lane_en  = 4'b1111;
      ram_wr_index = clr_cnt_q;
      ram_wr_data  = '0;
    end else if (DMEM_IF.dmem_wr_enable && !access_misaligned) begin
      ram_lane_en = lane_mask(size, byte_off);
      case (size)
        SZ_BYTE: ram_wr_data = {4{DMEM_IF.dmem_wr_data[7:0]}};
        SZ_HALF: ram_wr_data = {2{DMEM_IF.dmem_wr_data[15:0]}};
        default: ram_wr_data = DMEM_IF.dmem_wr_data;
      endcase
    end
  end

  byte_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk        (i_clock),
    .wr_index   (ram_wr_index),
    .wr_lane_en (ram_lane_en),
    .wr_data    (ram_wr_data),
    .rd_index   (word_index),
    .rd_data    (ram_rd_word)
  );

  // Next-state logic: the clear walks every word once and hands over to
  // READY right after the last one; in READY only the error counter moves.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    busy_d      = busy_q;
    err_count_d = err_count_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        busy_d    = 1'b1;
        if (clr_cnt_q == LAST_WORD) begin
          state_d = S_READY;
          busy_d  = 1'b0;
        end
      end
      S_READY: begin
        busy_d = 1'b0;
        if (store_dropped && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end
      end
    endcase
  end

  // State registers; reset restarts the clear from word 0 but leaves the
  // storage alone, the clear sequence is what zeroes it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      busy_q      <= 1'b1;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      busy_q      <= busy_d;
      err_count_q <= err_count_d;
    end
  end

  // Loads return the word shifted down by the byte offset; the core's load
  // unit does any masking or sign extension.
  assign DMEM_IF.dmem_rd_data = (state_q == S_READY) ? (ram_rd_word >> {byte_off, 3'b000}) : '0;

  assign o_busy       = busy_q;
  assign o_misaligned = access_misaligned;
  assign o_err_count  = err_count_q;

endmodule

// File: tb/tb_data_memory.sv
`timescale 1ns/1ps
module tb_data_memory;
  import riscv_defs::*;

  localparam int DEPTH = 16;

  logic                 i_clock = 1'b0;
  logic                 i_reset;
  logic [NB_FUNCT3-1:0] ld_st_funct3;
  logic                 busy;
  logic                 misaligned;
  logic [7:0]           err_count;

  dmem_if dmem_bus ();

  data_memory #(
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .DMEM_IF        (dmem_bus),
    .i_ld_st_funct3 (ld_st_funct3),
    .o_busy         (busy),
    .o_misaligned   (misaligned),
    .o_err_count    (err_count)
  );

  always #5 i_clock = ~i_clock;

  // Expected response for one stimulus cycle
  typedef struct {
    int          step;
    logic [31:0] rd;
    logic [31:0] rd_mask;
    logic        mis;
    logic        busy;
    logic [7:0]  err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain byte-addressed memory contents and counters
  logic [31:0] model_mem [DEPTH];
  int          model_busy_left;
  int          model_err;

  int   checks = 0;
  int   errors = 0;
  int   step = 0;
  logic check_valid = 1'b0;

  // Misalignment rule: half on odd byte, word (size 2 or 3) off a word boundary
  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    int off;
    sz  = int'(f3[1:0]);
    off = int'(addr % 4);
    if (sz == 1) return (off % 2) != 0;
    if (sz >= 2) return off != 0;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input int stp,
                             input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s step %0d actual 0x%08h required 0x%08h", name, stp, act, req);
    end
  endtask

  // Monitor: whenever the bench flags a checked cycle, pop and compare
  always @(negedge i_clock) begin : monitor
    exp_t e;
    if (check_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL queue_underflow step %0d actual 0 required 1", step);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rd_data", e.step, dmem_bus.dmem_rd_data & e.rd_mask, e.rd & e.rd_mask);
        checkOutput("misaligned", e.step, {31'b0, misaligned}, {31'b0, e.mis});
        checkOutput("busy", e.step, {31'b0, busy}, {31'b0, e.busy});
        checkOutput("err_count", e.step, {24'b0, err_count}, {24'b0, e.err});
      end
    end
  end

  // One bus cycle: predict, drive, let the edge pass, then update the model.
  // A nonzero want_mask replaces the model's read prediction by a constant.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic we, input logic [2:0] f3, input bit chk,
                               input logic [31:0] want = 32'h0,
                               input logic [31:0] want_mask = 32'h0);
    exp_t        e;
    int          idx;
    int          off;
    int          sz;
    int          nbytes;
    int          first;
    bit          busy_now;
    bit          mis;
    logic [31:0] w;
    idx      = int'((addr / 4) % DEPTH);
    off      = int'(addr % 4);
    sz       = int'(f3[1:0]);
    busy_now = (model_busy_left > 0);
    mis      = busy_now ? 1'b0 : model_mis(f3, addr);
    e.step    = step;
    e.busy    = busy_now;
    e.mis     = mis;
    e.err     = 8'(model_err);
    e.rd      = busy_now ? 32'h0 : (model_mem[idx] >> (8 * off));
    e.rd_mask = 32'hFFFF_FFFF;
    if (want_mask != 32'h0) begin
      e.rd      = want;
      e.rd_mask = want_mask;
    end
    dmem_bus.dmem_address   = addr;
    dmem_bus.dmem_wr_data   = data;
    dmem_bus.dmem_wr_enable = we;
    ld_st_funct3            = f3;
    if (chk) exp_q.push_back(e);
    check_valid = chk;
    @(posedge i_clock);
    #1;
    if (busy_now) begin
      model_busy_left--;
    end else if (we) begin
      if (mis) begin
        if (model_err < 255) model_err++;
      end else begin
        nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        first  = (sz == 0) ? off : (sz == 1) ? (off / 2) * 2 : 0;
        w = model_mem[idx];
        for (int k = 0; k < nbytes; k++) w[8*(first+k) +: 8] = data[8*k +: 8];
        model_mem[idx] = w;
      end
    end
    step++;
  endtask

  // Reset now (mid-cycle is fine), release just after a rising edge
  task automatic doReset();
    check_valid = 1'b0;
    i_reset = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_busy_left = DEPTH;
    model_err = 0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rdat;
    logic        rwe;
    logic [2:0]  rf;
    i_reset                 = 1'b0;
    dmem_bus.dmem_address   = '0;
    dmem_bus.dmem_wr_data   = '0;
    dmem_bus.dmem_wr_enable = 1'b0;
    ld_st_funct3            = '0;
    model_busy_left         = 0;
    model_err               = 0;
    @(posedge i_clock);
    #1;
    doReset();

    // Clear: busy for exactly DEPTH cycles, stores ignored, then all zero
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(32'(4 * i), 32'hDEAD_0000 + 32'(i), 1'b1, F3_SW, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(32'(4 * i), 32'h0, 1'b0, F3_LW, 1'b1, 32'h0, 32'hFFFF_FFFF);

    // Word store then byte store into lane 1
    applyStimulus(32'h8, 32'h1122_3344, 1'b1, F3_SW, 1'b1);
    applyStimulus(32'h9, 32'h0000_00AA, 1'b1, F3_SB, 1'b1);
    applyStimulus(32'h8, 32'h0, 1'b0, F3_LW, 1'b1, 32'h1122_AA44, 32'hFFFF_FFFF);
    applyStimulus(32'h9, 32'h0, 1'b0, F3_LB, 1'b1, 32'h0000_00AA, 32'h0000_00FF);

    // Half store into the upper half of word 1
    applyStimulus(32'h6, 32'h0000_BEEF, 1'b1, F3_SH, 1'b1);
    applyStimulus(32'h4, 32'h0, 1'b0, F3_LW, 1'b1, 32'hBEEF_0000, 32'hFFFF_FFFF);
    applyStimulus(32'h6, 32'h0, 1'b0, F3_LH, 1'b1, 32'h0000_BEEF, 32'hFFFF_FFFF);

    // Misaligned word store is dropped and counted
    applyStimulus(32'h5, 32'h1234_5678, 1'b1, F3_SW, 1'b1);
    applyStimulus(32'h4, 32'h0, 1'b0, F3_LW, 1'b1, 32'hBEEF_0000, 32'hFFFF_FFFF);

    // Wrap: 0x40 maps to word 0, same-cycle read shows the old value
    applyStimulus(32'h40, 32'hCAFE_F00D, 1'b1, F3_SW, 1'b1, 32'h0, 32'hFFFF_FFFF);
    applyStimulus(32'h0, 32'h0, 1'b0, F3_LW, 1'b1, 32'hCAFE_F00D, 32'hFFFF_FFFF);

    // Back-to-back byte stores accumulate in one word
    for (int i = 0; i < 4; i++)
      applyStimulus(32'h10 + 32'(i), 32'(8'h11 * (i + 1)), 1'b1, F3_SB, 1'b1);
    applyStimulus(32'h10, 32'h0, 1'b0, F3_LW, 1'b1, 32'h4433_2211, 32'hFFFF_FFFF);

    // 300 misaligned stores saturate the error counter
    for (int n = 0; n < 300; n++) begin
      ra = ($urandom & 32'hFC) | 32'($urandom_range(1, 3));
      applyStimulus(ra, $urandom, 1'b1, F3_SW, 1'b1);
    end
    applyStimulus(32'h4, 32'h0, 1'b0, F3_LW, 1'b1);

    // Random traffic across wrapped addresses and all sizes
    for (int n = 0; n < 400; n++) begin
      ra   = 32'($urandom_range(0, 255));
      rdat = $urandom;
      rwe  = 1'($urandom_range(0, 1));
      rf   = 3'($urandom_range(0, 7));
      applyStimulus(ra, rdat, rwe, rf, 1'b1);
    end

    // Reset in the middle of a clear, at word 7
    doReset();
    for (int i = 0; i < 7; i++)
      applyStimulus(32'(4 * i), $urandom, 1'b1, F3_SW, 1'b1);
    doReset();
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(32'($urandom_range(0, 63)), $urandom, 1'b1, F3_SW, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(32'(4 * i), 32'h0, 1'b0, F3_LW, 1'b1, 32'h0, 32'hFFFF_FFFF);

    check_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_leftover actual %0d required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit storage words, power of two, at least 4.
REQ-002 SHALL have port i_clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port DMEM_IF, interface dmem_if.mem: responder end of the data-memory interface.
REQ-005 SHALL take from DMEM_IF the inputs dmem_address (NB_ADDR, byte address), dmem_wr_data (NB_WORD) and dmem_wr_enable (1 bit).
REQ-006 SHALL drive DMEM_IF.dmem_rd_data, NB_WORD bits, as an output.
REQ-007 SHALL have port i_ld_st_funct3, input, NB_FUNCT3 bits: access size; bits [1:0] = 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-008 SHALL have port o_busy, output, 1 bit: high while the post-reset clear sequence runs.
REQ-009 SHALL have port o_misaligned, output, 1 bit: combinational flag for a misaligned current access.
REQ-010 SHALL have port o_err_count, output, 8 bits: saturating count of suppressed misaligned stores.

Function
REQ-011 SHALL compute the word index from dmem_address[$clog2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so out-of-range addresses wrap.
REQ-012 SHALL implement the two-state FSM {S_CLEAR, S_READY}.
REQ-013 SHALL, in S_CLEAR, write zero to word clr_cnt each cycle, increment clr_cnt, and move to S_READY in the cycle after writing word DEPTH_WORDS-1.
REQ-014 SHALL, in S_CLEAR, hold o_busy=1, dmem_rd_data=0 and o_misaligned=0, and ignore dmem_wr_enable.
REQ-015 SHALL, in S_READY, hold o_busy=0.
REQ-016 SHALL provide a combinational read path in S_READY: dmem_rd_data = addressed word logically shifted right by 8*dmem_address[1:0], zero-filled from the top.
REQ-017 SHALL perform a byte store (size 00) into lane dmem_address[1:0] using dmem_wr_data[7:0].
REQ-018 SHALL perform a half store (size 01) into lanes {2*dmem_address[1], +1} using dmem_wr_data[15:0].
REQ-019 SHALL perform a word store (size 10/11) of all 32 bits; in every store, untouched lanes keep their value.
REQ-020 SHALL assert o_misaligned when size=half and address[0]=1, or when size=word and address[1:0]!=0, regardless of dmem_wr_enable.
REQ-021 SHALL suppress a store while o_misaligned=1 and increment o_err_count, saturating at 255.
REQ-022 SHALL still return shifted data for a misaligned load, with o_misaligned=1.
REQ-023 SHALL, when a read and a write hit the same word in one cycle, return the pre-write contents; the new data is visible from the next cycle.
REQ-024 SHALL make back-to-back stores to the same word on consecutive cycles accumulate lane updates.

Reset
REQ-025 SHALL, on i_reset low, asynchronously set the state to S_CLEAR, clr_cnt to 0, o_err_count to 0 and o_busy to 1.
REQ-026 SHALL not reset storage contents asynchronously; the contents are zeroed only by the clear sequence.
REQ-027 SHALL, if reset is asserted mid-clear, restart the clear from word 0 after release.
REQ-028 SHALL begin clearing on the first rising edge after reset release.

Structure
REQ-029 SHALL import NB_WORD, NB_ADDR, NB_FUNCT3 and the F3_* encodings from riscv_defs.
REQ-030 SHALL add the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state typedef to riscv_defs.
REQ-031 SHALL place storage in a sub-module byte_lane_ram: 4 lanes of DEPTH_WORDS x 8, one write-enable per lane, asynchronous read.
REQ-032 SHALL place lane-enable generation, the FSM, the counters and read alignment in data_memory.

Verification
REQ-033 SHALL cover: release reset, DEPTH_WORDS=16 -> o_busy high exactly 16 cycles, then every word reads 0x00000000.
REQ-034 SHALL cover: SW 0x11223344 to 0x8, then SB 0xAA to 0x9 -> word 0x8 reads 0x1122AA44, and a byte read at 0x9 returns 0x000000AA.
REQ-035 SHALL cover: SH 0xBEEF to 0x6 -> a read at 0x4 returns 0xBEEF0000 and a read at 0x6 returns 0x0000BEEF.
REQ-036 SHALL cover: SW to 0x5 -> o_misaligned=1, memory unchanged, o_err_count=1; 300 such stores -> o_err_count=255.
REQ-037 SHALL cover: pulse reset at clear word 7 -> clear restarts at word 0, o_busy high for a full DEPTH_WORDS cycles, writes issued during the clear have no effect.
REQ-038 SHALL cover: SW to address 0x40 with DEPTH_WORDS=16 -> data lands in word 0 (wrap), and the same-cycle read returns the old value.
